vend_seq_ctrl: RTL



---
 rtl/vend_pkg.sv | 22 ++
 rtl/vend_timer.sv | 38 +++
 rtl/vend_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencing controller.
//   - state codes shown on the display bus
//   - width of half-yuan quantities (credit, refund)
//   - default timing constants for a 50 MHz clock
package vend_pkg;

  localparam int unsigned HALF_W = 4;

  localparam int unsigned DEF_PRICE_HALVES = 5;
  localparam int unsigned DEF_TIMEOUT_CYC  = 250_000_000;
  localparam int unsigned DEF_PULSE_CYC    = 25_000_000;
  localparam int unsigned DEF_GAP_CYC      = 25_000_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VEND    = 3'd2,
    ST_RET_ON  = 3'd3,
    ST_RET_GAP = 3'd4
  } vend_state_e;

endpackage

// File: rtl/vend_timer.sv
// Shared interval counter for the vending controller.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart the count at 0 (wins over en_i)
//   en_i          : advance the count by one
//   term_i        : terminal count for the current interval
//   done_o        : high while the count equals term_i
module vend_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] term_i,
  output logic        done_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == term_i);

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequencing controller: accumulates credit from one-cycle coin
// flags, fires a timed vend strobe at the price, then returns change or a
// refund as a train of timed half-yuan pulses.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   coin_half, coin_one : one-cycle coin flags (both together add 3 halves)
//   cancel              : one-cycle refund request
//   credit              : current credit in half-yuan units
//   vend_out            : dispense strobe, PULSE_CYC cycles
//   change_out          : one PULSE_CYC pulse per half-yuan returned
//   coin_reject         : one-cycle pulse after a coin arrives while busy
//   busy                : high in VEND, RET_ON, RET_GAP
//   state_o             : state code for the display
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_HALVES = DEF_PRICE_HALVES,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int unsigned PULSE_CYC    = DEF_PULSE_CYC,
  parameter int unsigned GAP_CYC      = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_half,
  input  logic              coin_one,
  input  logic              cancel,
  output logic [HALF_W-1:0] credit,
  output logic              vend_out,
  output logic              change_out,
  output logic              coin_reject,
  output logic              busy,
  output logic [2:0]        state_o
);

  localparam logic [4:0]  PRICE5       = 5'(PRICE_HALVES);
  localparam logic [31:0] TERM_PULSE   = 32'(PULSE_CYC - 1);
  localparam logic [31:0] TERM_GAP     = 32'(GAP_CYC - 1);
  localparam logic [31:0] TERM_TIMEOUT = 32'(TIMEOUT_CYC - 1);

  vend_state_e       state_q, state_d;
  logic [HALF_W-1:0] credit_q, credit_d;
  logic [HALF_W-1:0] refund_q, refund_d;
  logic              vend_q, change_q, reject_q, busy_q;

  logic        coin;
  logic [4:0]  add5;
  logic [4:0]  sum5;
  logic        restart;
  logic        tmr_clr;
  logic        tmr_done;
  logic [31:0] tmr_term;

  assign coin = coin_half | coin_one;
  assign add5 = 5'({coin_one, coin_half});
  assign sum5 = {1'b0, credit_q} + add5;

  // One timer serves every interval; its terminal count follows the state.
  always_comb begin
    case (state_q)
      ST_COLLECT: tmr_term = TERM_TIMEOUT;
      ST_RET_GAP: tmr_term = TERM_GAP;
      default:    tmr_term = TERM_PULSE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    refund_d = refund_q;
    restart  = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // Cancel is checked before the vend threshold so a coin arriving
        // with cancel is refunded rather than spent.
        if (cancel && (state_q == ST_COLLECT || coin)) begin
          state_d  = ST_RET_ON;
          refund_d = sum5[HALF_W-1:0];
          credit_d = '0;
        end else if (coin) begin
          if (sum5 >= PRICE5) begin
            state_d  = ST_VEND;
            refund_d = 4'(sum5 - PRICE5);
            credit_d = '0;
          end else begin
            state_d  = ST_COLLECT;
            credit_d = sum5[HALF_W-1:0];
            restart  = 1'b1;
          end
        end else if (state_q == ST_COLLECT && tmr_done) begin
          state_d  = ST_RET_ON;
          refund_d = credit_q;
          credit_d = '0;
        end
      end
      ST_VEND: begin
        if (tmr_done) begin
          state_d = (refund_q != '0) ? ST_RET_ON : ST_IDLE;
        end
      end
      ST_RET_ON: begin
        if (tmr_done) begin
          state_d  = ST_RET_GAP;
          refund_d = refund_q - 4'd1;
        end
      end
      ST_RET_GAP: begin
        if (tmr_done) begin
          state_d = (refund_q != '0) ? ST_RET_ON : ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        refund_d = '0;
      end
    endcase
  end

  // Any state change or a fresh coin in COLLECT starts a new interval.
  assign tmr_clr = (state_d != state_q) || restart;

  vend_timer u_timer (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (state_q != ST_IDLE),
    .term_i (tmr_term),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      refund_q <= '0;
      vend_q   <= 1'b0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      refund_q <= refund_d;
      // Strobes are registered from the next state so they align exactly
      // with the state they belong to.
      vend_q   <= (state_d == ST_VEND);
      change_q <= (state_d == ST_RET_ON);
      busy_q   <= (state_d == ST_VEND) || (state_d == ST_RET_ON) ||
                  (state_d == ST_RET_GAP);
      reject_q <= coin && ((state_q == ST_VEND) || (state_q == ST_RET_ON) ||
                           (state_q == ST_RET_GAP));
    end
  end

  assign credit      = credit_q;
  assign vend_out    = vend_q;
  assign change_out  = change_q;
  assign coin_reject = reject_q;
  assign busy        = busy_q;
  assign state_o     = state_q;

endmodule
